// File: rtl/udp_tx_scheduler_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM state encoding,
// payload length limit and the MII/UDP framing constants used by the tx engine.
package udp_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_PHY_RST   = 3'd0,
        ST_PHY_WAIT  = 3'd1,
        ST_IDLE      = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } sched_state_t;

    // Largest UDP payload that fits a 1500-byte MTU (1500 - 20 IP - 8 UDP).
    localparam int UDP_MAX_LEN = 1472;

    // Framing constants shared with the UDP/MII tx engine.
    localparam int          MII_PREAMBLE_BYTES = 8;
    localparam int          ETH_HDR_BYTES      = 14;
    localparam int          IPV4_HDR_BYTES     = 20;
    localparam int          UDP_HDR_BYTES      = 8;
    localparam int          ETH_FCS_BYTES      = 4;
    localparam logic [15:0] ETH_TYPE_IPV4      = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP       = 8'd17;

    // Largest of four values, used to size the shared cycle counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester
// strictly after the pointer, wrapping around, as a one-hot winner.
module udp_tx_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_eligible,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_winner,
    output logic                       o_any
);

    localparam int PTR_W = $clog2(NUM_REQ);

    int               w_sum;
    logic [PTR_W-1:0] w_idx;

    // Scan from pointer+1 upward with wrap; the first eligible index wins.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = PTR_W'(w_sum);
            if (!o_any && i_eligible[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                o_any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// UDP transmit scheduler: sequences the PHY reset, then shares the single
// UDP frame engine among NUM_REQ requesters with round-robin grants,
// inter-frame gap enforcement and a per-frame timeout.
module udp_tx_scheduler
    import udp_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 11,
    parameter int MAX_LEN        = UDP_MAX_LEN,
    parameter int PHY_RST_CYCLES = 10000,
    parameter int PHY_SETTLE_CYC = 5000,
    parameter int IFG_CYCLES     = 48,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_tx_start,
    output logic [LEN_W-1:0]         o_tx_len,
    input  logic                     i_tx_done,
    output logic [NUM_REQ-1:0]       o_done_pulse,
    output logic                     o_err_timeout,
    output logic                     o_phy_rst_n,
    output logic                     o_ready
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = max4(PHY_RST_CYCLES, PHY_SETTLE_CYC, IFG_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] PHY_RST_LAST = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(PHY_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V    = LEN_W'(MAX_LEN);

    sched_state_t       r_state;
    sched_state_t       w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;

    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_start;
    logic [LEN_W-1:0]   r_tx_len;
    logic [NUM_REQ-1:0] r_done_pulse;
    logic               r_err_timeout;
    logic               r_phy_rst_n;
    logic               r_ready;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_winner;
    logic               w_any;
    logic [PTR_W-1:0]   w_win_idx;
    logic [LEN_W-1:0]   w_win_len;
    logic               w_cnt_last;
    logic               w_cnt_clear;
    logic               w_done_hit;
    logic               w_timeout_hit;

    // A request only competes when its length is a legal UDP payload size.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = i_req[i]
                         && (i_req_len[i*LEN_W +: LEN_W] != '0)
                         && (i_req_len[i*LEN_W +: LEN_W] <= MAX_LEN_V);
        end
    end

    udp_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    // Convert the one-hot winner into its index and pick out its length.
    always_comb begin
        w_win_idx = '0;
        w_win_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PTR_W'(i);
                w_win_len = i_req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Terminal count of the shared counter depends on which phase is timing.
    always_comb begin
        w_cnt_last = 1'b0;
        case (r_state)
            ST_PHY_RST:   w_cnt_last = (r_cnt == PHY_RST_LAST);
            ST_PHY_WAIT:  w_cnt_last = (r_cnt == SETTLE_LAST);
            ST_WAIT_DONE: w_cnt_last = (r_cnt == TIMEOUT_LAST);
            ST_GAP:       w_cnt_last = (r_cnt == IFG_LAST);
            default:      w_cnt_last = 1'b0;
        endcase
    end

    assign w_done_hit    = (r_state == ST_WAIT_DONE) && i_tx_done;
    assign w_timeout_hit = (r_state == ST_WAIT_DONE) && !i_tx_done && w_cnt_last;

    // The timeout is measured from tx_start, so START->WAIT_DONE keeps counting.
    assign w_cnt_clear = (w_state_next != r_state) && (r_state != ST_START);

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_PHY_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PHY_RST:   if (w_cnt_last) w_state_next = ST_PHY_WAIT;
            ST_PHY_WAIT:  if (w_cnt_last) w_state_next = ST_IDLE;
            ST_IDLE:      if (w_any) w_state_next = ST_START;
            ST_START:     w_state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (w_done_hit || w_timeout_hit) w_state_next = ST_GAP;
            ST_GAP:       if (w_cnt_last) w_state_next = ST_IDLE;
            default:      w_state_next = ST_PHY_RST;
        endcase
    end

    // Shared saturating cycle counter, restarted on each phase change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Output registers, round-robin pointer and single-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant       <= '0;
            r_tx_start    <= 1'b0;
            r_tx_len      <= '0;
            r_done_pulse  <= '0;
            r_err_timeout <= 1'b0;
            r_phy_rst_n   <= 1'b0;
            r_ready       <= 1'b0;
            r_ptr         <= PTR_W'(NUM_REQ - 1);
        end else begin
            r_tx_start    <= 1'b0;
            r_done_pulse  <= '0;
            r_err_timeout <= 1'b0;
            r_phy_rst_n   <= (w_state_next != ST_PHY_RST);
            if (w_state_next == ST_IDLE) begin
                r_ready <= 1'b1;
            end
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant    <= w_winner;
                r_tx_len   <= w_win_len;
                r_tx_start <= 1'b1;
                r_ptr      <= w_win_idx;
            end
            if (w_done_hit) begin
                r_done_pulse <= r_grant;
                r_grant      <= '0;
                r_tx_len     <= '0;
            end
            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
                r_grant       <= '0;
                r_tx_len      <= '0;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_tx_start    = r_tx_start;
    assign o_tx_len      = r_tx_len;
    assign o_done_pulse  = r_done_pulse;
    assign o_err_timeout = r_err_timeout;
    assign o_phy_rst_n   = r_phy_rst_n;
    assign o_ready       = r_ready;

endmodule
